// File: rtl/store_buffer.sv
// In-order store buffer between MEM and the D-cache with commit tracking and load lookup.
// Define STORE_BUFFER_FWD_EN to enable word store-to-load forwarding.
module store_buffer #(
  parameter int N               = 4,
  parameter int WORD_SIZE       = 32,
  parameter int ROB_ENTRY_WIDTH = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       st_valid,
  input  logic [WORD_SIZE-1:0]       st_addr,
  input  logic [WORD_SIZE-1:0]       st_data,
  input  logic                       st_byte,
  input  logic [ROB_ENTRY_WIDTH-1:0] st_rob_id,
  output logic                       full,
  output logic                       empty,
  input  logic                       sb_store_permission,
  input  logic [ROB_ENTRY_WIDTH-1:0] sb_rob_id,
  input  logic                       flush,
  output logic                       dc_req_valid,
  output logic [WORD_SIZE-1:0]       dc_req_addr,
  output logic [WORD_SIZE-1:0]       dc_req_data,
  output logic                       dc_req_byte,
  input  logic                       dc_req_ready,
  input  logic                       ld_valid,
  input  logic [WORD_SIZE-1:0]       ld_addr,
  output logic                       ld_hit,
  output logic                       fwd_valid,
  output logic [WORD_SIZE-1:0]       fwd_data
);

  localparam int PW = $clog2(N);

  typedef enum logic [1:0] {
    E_FREE,
    E_PEND,
    E_COMM
  } ent_e;

  typedef enum logic {
    D_IDLE,
    D_REQ
  } drain_e;

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [PW:0]   count_q, count_d;

  ent_e                       st_q   [N];
  ent_e                       st_d   [N];
  logic [WORD_SIZE-1:0]       addr_q [N];
  logic [WORD_SIZE-1:0]       addr_d [N];
  logic [WORD_SIZE-1:0]       data_q [N];
  logic [WORD_SIZE-1:0]       data_d [N];
  logic                       byte_q [N];
  logic                       byte_d [N];
  logic [ROB_ENTRY_WIDTH-1:0] rob_q  [N];
  logic [ROB_ENTRY_WIDTH-1:0] rob_d  [N];

  drain_e               drain_q, drain_d;
  logic [WORD_SIZE-1:0] dc_addr_q, dc_addr_d;
  logic [WORD_SIZE-1:0] dc_data_q, dc_data_d;
  logic                 dc_byte_q, dc_byte_d;

  logic          enq;
  logic          deq;
  logic          commit_hit;
  logic [PW-1:0] commit_idx;
  logic [PW:0]   live;
  logic [PW-1:0] next_head;

  assign full  = (count_q == (PW+1)'(N));
  assign empty = (count_q == '0);
  assign enq   = st_valid && !full && !flush;
  assign deq   = (drain_q == D_REQ) && dc_req_ready;

  // Oldest pending entry carrying the committed ROB id.
  always_comb begin : commit_find
    logic [PW-1:0] idx;
    commit_hit = 1'b0;
    commit_idx = '0;
    idx        = '0;
    for (int i = 0; i < N; i++) begin
      idx = head_q + PW'(i);
      if (!commit_hit && sb_store_permission &&
          st_q[idx] == E_PEND && rob_q[idx] == sb_rob_id) begin
        commit_hit = 1'b1;
        commit_idx = idx;
      end
    end
  end

  always_comb begin : ent_next
    st_d    = st_q;
    addr_d  = addr_q;
    data_d  = data_q;
    byte_d  = byte_q;
    rob_d   = rob_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    live    = '0;
    if (commit_hit) begin
      st_d[commit_idx] = E_COMM;
    end
    if (deq) begin
      st_d[head_q] = E_FREE;
      head_d       = head_q + PW'(1);
    end
    if (flush) begin
      for (int i = 0; i < N; i++) begin
        if (st_d[i] == E_PEND) st_d[i] = E_FREE;
      end
      for (int i = 0; i < N; i++) begin
        if (st_d[i] != E_FREE) live = live + (PW+1)'(1);
      end
      count_d = live;
      tail_d  = head_d + live[PW-1:0];
    end else begin
      count_d = count_q + (PW+1)'(enq) - (PW+1)'(deq);
      if (enq) begin
        st_d[tail_q]   = E_PEND;
        addr_d[tail_q] = st_addr;
        data_d[tail_q] = st_data;
        byte_d[tail_q] = st_byte;
        rob_d[tail_q]  = st_rob_id;
        tail_d         = tail_q + PW'(1);
      end
    end
  end

  assign next_head = head_q + PW'(1);

  // Drain request is registered; a committed successor keeps REQ up back-to-back.
  always_comb begin : drain_next
    drain_d   = drain_q;
    dc_addr_d = dc_addr_q;
    dc_data_d = dc_data_q;
    dc_byte_d = dc_byte_q;
    unique case (drain_q)
      D_IDLE: begin
        if (st_d[head_q] == E_COMM) begin
          drain_d   = D_REQ;
          dc_addr_d = addr_q[head_q];
          dc_data_d = data_q[head_q];
          dc_byte_d = byte_q[head_q];
        end
      end
      D_REQ: begin
        if (dc_req_ready) begin
          if (st_d[next_head] == E_COMM) begin
            dc_addr_d = addr_q[next_head];
            dc_data_d = data_q[next_head];
            dc_byte_d = byte_q[next_head];
          end else begin
            drain_d = D_IDLE;
          end
        end
      end
      default: drain_d = D_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      drain_q   <= D_IDLE;
      dc_addr_q <= '0;
      dc_data_q <= '0;
      dc_byte_q <= 1'b0;
      for (int i = 0; i < N; i++) begin
        st_q[i]   <= E_FREE;
        addr_q[i] <= '0;
        data_q[i] <= '0;
        byte_q[i] <= 1'b0;
        rob_q[i]  <= '0;
      end
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      drain_q   <= drain_d;
      dc_addr_q <= dc_addr_d;
      dc_data_q <= dc_data_d;
      dc_byte_q <= dc_byte_d;
      st_q      <= st_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      byte_q    <= byte_d;
      rob_q     <= rob_d;
    end
  end

  assign dc_req_valid = (drain_q == D_REQ);
  assign dc_req_addr  = dc_addr_q;
  assign dc_req_data  = dc_data_q;
  assign dc_req_byte  = dc_byte_q;

  // Scan oldest to youngest so the last match is the youngest store.
  always_comb begin : ld_check
    logic [PW-1:0] idx;
    logic          hit;
`ifdef STORE_BUFFER_FWD_EN
    logic                 y_byte;
    logic [WORD_SIZE-1:0] y_data;
    y_byte = 1'b0;
    y_data = '0;
`endif
    idx = '0;
    hit = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx = head_q + PW'(i);
      if (st_q[idx] != E_FREE &&
          addr_q[idx][WORD_SIZE-1:2] == ld_addr[WORD_SIZE-1:2]) begin
        hit = 1'b1;
`ifdef STORE_BUFFER_FWD_EN
        y_byte = byte_q[idx];
        y_data = data_q[idx];
`endif
      end
    end
    ld_hit = ld_valid && hit;
`ifdef STORE_BUFFER_FWD_EN
    fwd_valid = ld_hit && !y_byte;
    fwd_data  = fwd_valid ? y_data : '0;
`else
    fwd_valid = 1'b0;
    fwd_data  = '0;
`endif
  end

  // A permission must always name a pending store.
  always @(posedge clk) begin
    if (rst && sb_store_permission) assert (commit_hit);
  end

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed table, corner sequences and a
// randomized run against a queue-based model.
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_byte;
  logic [2:0]  st_rob_id;
  logic        full;
  logic        empty;
  logic        sb_store_permission;
  logic [2:0]  sb_rob_id;
  logic        flush;
  logic        dc_req_valid;
  logic [31:0] dc_req_addr;
  logic [31:0] dc_req_data;
  logic        dc_req_byte;
  logic        dc_req_ready;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic        ld_hit;
  logic        fwd_valid;
  logic [31:0] fwd_data;

  store_buffer dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
    .st_byte(st_byte), .st_rob_id(st_rob_id),
    .full(full), .empty(empty),
    .sb_store_permission(sb_store_permission), .sb_rob_id(sb_rob_id),
    .flush(flush),
    .dc_req_valid(dc_req_valid), .dc_req_addr(dc_req_addr),
    .dc_req_data(dc_req_data), .dc_req_byte(dc_req_byte),
    .dc_req_ready(dc_req_ready),
    .ld_valid(ld_valid), .ld_addr(ld_addr),
    .ld_hit(ld_hit), .fwd_valid(fwd_valid), .fwd_data(fwd_data)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference model: queue of live stores, oldest first.
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        b;
    logic [2:0]  rob;
    bit          com;
  } ent_t;

  ent_t       mq[$];
  logic [2:0] next_rob = 3'd0;

  function automatic bit oldest_pending(output logic [2:0] id);
    id = 3'd0;
    foreach (mq[i]) if (!mq[i].com) begin
      id = mq[i].rob;
      return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic void model_update();
    bit   drn;
    bit   fullp;
    bit   found;
    ent_t keep[$];
    ent_t e;
    drn   = mq.size() > 0 && mq[0].com && dc_req_ready;
    fullp = mq.size() == 4;
    found = 1'b0;
    if (sb_store_permission)
      foreach (mq[i]) if (!found && !mq[i].com && mq[i].rob == sb_rob_id) begin
        mq[i].com = 1'b1;
        found     = 1'b1;
      end
    if (drn) void'(mq.pop_front());
    if (flush) begin
      foreach (mq[i]) if (mq[i].com) keep.push_back(mq[i]);
      mq = keep;
    end else if (st_valid && !fullp) begin
      e.addr = st_addr;
      e.data = st_data;
      e.b    = st_byte;
      e.rob  = st_rob_id;
      e.com  = 1'b0;
      mq.push_back(e);
      next_rob = next_rob + 3'd1;
    end
  endfunction

  task automatic check_model();
    bit          edv;
    bit          hit;
    bit          yb;
    logic [31:0] yd;
    bit          efv;
    logic [31:0] efd;
    edv = mq.size() > 0 && mq[0].com;
    chk("full", full, mq.size() == 4);
    chk("empty", empty, mq.size() == 0);
    chk("dc_req_valid", dc_req_valid, edv);
    if (edv) begin
      chk("dc_req_addr", dc_req_addr, mq[0].addr);
      chk("dc_req_data", dc_req_data, mq[0].data);
      chk("dc_req_byte", dc_req_byte, mq[0].b);
    end
    hit = 1'b0;
    yb  = 1'b0;
    yd  = '0;
    foreach (mq[i]) if (mq[i].addr[31:2] == ld_addr[31:2]) begin
      hit = 1'b1;
      yb  = mq[i].b;
      yd  = mq[i].data;
    end
    hit = hit && ld_valid;
`ifdef STORE_BUFFER_FWD_EN
    efv = hit && !yb;
    efd = efv ? yd : 32'd0;
`else
    efv = 1'b0;
    efd = 32'd0;
`endif
    chk("ld_hit", ld_hit, hit);
    chk("fwd_valid", fwd_valid, efv);
    chk("fwd_data", fwd_data, efd);
  endtask

  task automatic step();
    @(negedge clk);
    check_model();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_in();
    st_valid            = 1'b0;
    st_byte             = 1'b0;
    sb_store_permission = 1'b0;
    flush               = 1'b0;
    ld_valid            = 1'b0;
  endtask

  task automatic enq(input logic [31:0] a, input logic [31:0] d,
                     input logic b, input logic [2:0] id);
    st_valid  = 1'b1;
    st_addr   = a;
    st_data   = d;
    st_byte   = b;
    st_rob_id = id;
  endtask

  task automatic drain_all();
    logic [2:0] id;
    int         k;
    k = 0;
    idle_in();
    dc_req_ready = 1'b1;
    while (mq.size() != 0 && k < 40) begin
      sb_store_permission = oldest_pending(id);
      sb_rob_id           = id;
      step();
      k++;
    end
    sb_store_permission = 1'b0;
    if (k >= 40) chk("drain_timeout", 1'b0, 1'b1);
    @(negedge clk);
    chk("drain_empty", empty, 1'b1);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit          stv;
    logic [31:0] sa;
    logic [31:0] sd;
    logic [2:0]  sid;
    bit          pm;
    logic [2:0]  pid;
    bit          rdy;
    bit          ef;
    bit          ee;
    bit          edv;
    logic [31:0] ea;
    logic [31:0] ed;
  } vec_t;

  function automatic vec_t mk(bit stv, logic [31:0] sa, logic [2:0] sid,
                              bit pm, logic [2:0] pid, bit rdy,
                              bit ef, bit ee, bit edv, logic [31:0] ea);
    vec_t v;
    v.stv = stv;
    v.sa  = sa;
    v.sd  = 32'hA0 + 32'(sid);
    v.sid = sid;
    v.pm  = pm;
    v.pid = pid;
    v.rdy = rdy;
    v.ef  = ef;
    v.ee  = ee;
    v.edv = edv;
    v.ea  = ea;
    v.ed  = 32'hA0 + 32'(ea[3:2]);
    return v;
  endfunction

  vec_t tbl[11];

  initial begin
    logic [31:0] wq[$];
    logic [2:0]  id;

    tbl[0]  = mk(1, 32'h10, 3'd0, 0, 3'd0, 0, 0, 1, 0, 32'h0);
    tbl[1]  = mk(1, 32'h14, 3'd1, 0, 3'd0, 0, 0, 0, 0, 32'h0);
    tbl[2]  = mk(1, 32'h18, 3'd2, 0, 3'd0, 0, 0, 0, 0, 32'h0);
    tbl[3]  = mk(1, 32'h1C, 3'd3, 0, 3'd0, 0, 0, 0, 0, 32'h0);
    tbl[4]  = mk(1, 32'h20, 3'd4, 0, 3'd0, 0, 1, 0, 0, 32'h0);
    tbl[5]  = mk(0, 32'h0,  3'd0, 1, 3'd0, 1, 1, 0, 0, 32'h0);
    tbl[6]  = mk(0, 32'h0,  3'd0, 1, 3'd1, 1, 1, 0, 1, 32'h10);
    tbl[7]  = mk(0, 32'h0,  3'd0, 1, 3'd2, 1, 0, 0, 1, 32'h14);
    tbl[8]  = mk(0, 32'h0,  3'd0, 1, 3'd3, 1, 0, 0, 1, 32'h18);
    tbl[9]  = mk(0, 32'h0,  3'd0, 0, 3'd0, 1, 0, 0, 1, 32'h1C);
    tbl[10] = mk(0, 32'h0,  3'd0, 0, 3'd0, 1, 0, 1, 0, 32'h0);

    rst          = 1'b0;
    st_addr      = '0;
    st_data      = '0;
    st_rob_id    = '0;
    sb_rob_id    = '0;
    ld_addr      = '0;
    dc_req_ready = 1'b0;
    idle_in();
    #1;
    chk("rst_empty", empty, 1'b1);
    chk("rst_full", full, 1'b0);
    chk("rst_dcv", dc_req_valid, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    ld_valid = 1'b1;
    ld_addr  = 32'h0;
    #1;
    chk("rst_ld_hit", ld_hit, 1'b0);
    chk("rst_fwd_valid", fwd_valid, 1'b0);
    chk("rst_fwd_data", fwd_data, 32'd0);
    chk("rst_dc_addr", dc_req_addr, 32'd0);
    chk("rst_dc_data", dc_req_data, 32'd0);
    ld_valid = 1'b0;
    @(posedge clk);
    #1;

    // Fill, reject fifth, then commit and drain in order.
    foreach (tbl[i]) begin
      st_valid            = tbl[i].stv;
      st_addr             = tbl[i].sa;
      st_data             = tbl[i].sd;
      st_rob_id           = tbl[i].sid;
      sb_store_permission = tbl[i].pm;
      sb_rob_id           = tbl[i].pid;
      dc_req_ready        = tbl[i].rdy;
      @(negedge clk);
      chk("tbl_full", full, tbl[i].ef);
      chk("tbl_empty", empty, tbl[i].ee);
      chk("tbl_dcv", dc_req_valid, tbl[i].edv);
      if (tbl[i].edv) begin
        chk("tbl_dc_addr", dc_req_addr, tbl[i].ea);
        chk("tbl_dc_data", dc_req_data, tbl[i].ed);
      end
      @(posedge clk);
      model_update();
      #1;
    end
    idle_in();

    // Flush keeps the committed store, kills the pending one.
    dc_req_ready = 1'b0;
    enq(32'h100, 32'hAA, 1'b0, 3'd1);
    step();
    enq(32'h104, 32'hBB, 1'b0, 3'd2);
    step();
    idle_in();
    sb_store_permission = 1'b1;
    sb_rob_id           = 3'd1;
    step();
    sb_store_permission = 1'b0;
    flush               = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_dcv", dc_req_valid, 1'b1);
    chk("flush_addr", dc_req_addr, 32'h100);
    dc_req_ready = 1'b1;
    step();
    chk("flush_empty", empty, 1'b1);
    chk("flush_no_b", dc_req_valid, 1'b0);

    // Back-pressure: request held stable, permission meanwhile kept.
    dc_req_ready = 1'b0;
    enq(32'h300, 32'h33, 1'b0, 3'd3);
    step();
    enq(32'h304, 32'h44, 1'b0, 3'd4);
    step();
    idle_in();
    sb_store_permission = 1'b1;
    sb_rob_id           = 3'd3;
    step();
    for (int c = 0; c < 5; c++) begin
      sb_store_permission = (c == 1);
      sb_rob_id           = 3'd4;
      step();
      chk("stall_dcv", dc_req_valid, 1'b1);
      chk("stall_addr", dc_req_addr, 32'h300);
      chk("stall_data", dc_req_data, 32'h33);
    end
    sb_store_permission = 1'b0;
    dc_req_ready        = 1'b1;
    step();
    chk("stall_next_addr", dc_req_addr, 32'h304);
    chk("stall_next_dcv", dc_req_valid, 1'b1);
    step();
    chk("stall_empty", empty, 1'b1);

    // Load lookup against pending word and byte stores.
    dc_req_ready = 1'b0;
    enq(32'h200, 32'hDEADBEEF, 1'b0, 3'd5);
    step();
    idle_in();
    ld_valid = 1'b1;
    ld_addr  = 32'h200;
    #1;
    chk("ld_hit_word", ld_hit, 1'b1);
`ifdef STORE_BUFFER_FWD_EN
    chk("fwd_valid_word", fwd_valid, 1'b1);
    chk("fwd_data_word", fwd_data, 32'hDEADBEEF);
`else
    chk("fwd_valid_word", fwd_valid, 1'b0);
    chk("fwd_data_word", fwd_data, 32'h0);
`endif
    ld_addr = 32'h208;
    #1;
    chk("ld_miss", ld_hit, 1'b0);
    enq(32'h201, 32'h5A, 1'b1, 3'd6);
    step();
    idle_in();
    ld_valid = 1'b1;
    ld_addr  = 32'h202;
    #1;
    chk("ld_hit_byte", ld_hit, 1'b1);
    chk("fwd_byte", fwd_valid, 1'b0);
    step();
    ld_valid = 1'b0;
    flush    = 1'b1;
    step();
    flush = 1'b0;
    chk("ld_flush_empty", empty, 1'b1);

    // Steady state with simultaneous enqueue, commit and drain.
    dc_req_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      enq(32'h400 + 32'(4 * c), 32'h4000 + 32'(c), 1'b0, next_rob);
      wq.push_back(st_addr);
      sb_store_permission = oldest_pending(id);
      sb_rob_id           = id;
      step();
    end
    dc_req_ready = 1'b1;
    for (int c = 3; c < 11; c++) begin
      enq(32'h400 + 32'(4 * (c % 8)), 32'h4000 + 32'(c), 1'b0, next_rob);
      wq.push_back(st_addr);
      sb_store_permission = oldest_pending(id);
      sb_rob_id           = id;
      @(negedge clk);
      chk("wrap_order", dc_req_addr, wq.pop_front());
      chk("wrap_full", full, 1'b0);
      chk("wrap_empty", empty, 1'b0);
      check_model();
      @(posedge clk);
      model_update();
      #1;
    end
    drain_all();

    // Randomized traffic.
    for (int c = 0; c < 600; c++) begin
      st_valid = $urandom_range(0, 1) == 1;
      st_byte  = $urandom_range(0, 3) == 0;
      st_addr  = 32'h100 + 32'($urandom_range(0, 7) * 4);
      if (st_byte) st_addr = st_addr + 32'($urandom_range(0, 3));
      st_data             = $urandom;
      st_rob_id           = next_rob;
      sb_store_permission = oldest_pending(id) && ($urandom_range(0, 1) == 1);
      sb_rob_id           = id;
      flush               = $urandom_range(0, 15) == 0;
      dc_req_ready        = $urandom_range(0, 9) < 7;
      ld_valid            = $urandom_range(0, 1) == 1;
      ld_addr             = 32'h100 + 32'($urandom_range(0, 35));
      step();
    end
    drain_all();

    // Reset during an outstanding request drops it at once.
    dc_req_ready = 1'b0;
    enq(32'h500, 32'h55, 1'b0, next_rob);
    step();
    idle_in();
    sb_store_permission = 1'b1;
    sb_rob_id           = mq[0].rob;
    step();
    sb_store_permission = 1'b0;
    chk("mid_dcv", dc_req_valid, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_dcv", dc_req_valid, 1'b0);
    chk("mid_rst_empty", empty, 1'b1);
    mq.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
